// File: rtl/riscv32s_pkg.sv
// Constants and types shared by the riscv32s FPGA top, its data RAM and the
// end-of-program RAM dump streamer.
package riscv32s_pkg;

  localparam int         DUMP_RAMDEPTH = 1024;
  localparam logic [7:0] DUMP_HDR_BYTE = 8'hA5;
  localparam logic [7:0] DUMP_TRL_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_HDR,
    DUMP_RD,
    DUMP_WAIT,
    DUMP_SEND,
    DUMP_TRL,
    DUMP_DONE
  } dump_state_e;

endpackage

// File: rtl/ram_dump_streamer_if.sv
// Byte stream with valid/ready handshake from the dump streamer to the UART
// transmitter.
interface ram_dump_streamer_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/ram_dump_streamer_byte_serializer.sv
// Splits one 32-bit RAM word into four bytes, least significant first.
// next_byte is the byte that will sit at the head after the coming edge.
module byte_serializer (
  input  logic        clock,
  input  logic        nreset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        advance,
  output logic [7:0]  next_byte,
  output logic        last
);

  logic [31:0] shreg;
  logic [1:0]  cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= word;
      cnt   <= '0;
    end else if (advance) begin
      shreg <= {8'h00, shreg[31:8]};
      cnt   <= cnt + 2'd1;
    end
  end

  assign last = (cnt == 2'd3);

  // NOTE: the default first assignment keeps this combinational block from
  // inferring a latch on paths that do not load or advance.
  always_comb begin
    next_byte = shreg[7:0];
    if (load) begin
      next_byte = word[7:0];
    end else if (advance) begin
      next_byte = shreg[15:8];
    end
  end

endmodule

// File: rtl/ram_dump_streamer.sv
// Halts the core once the program counter passes the program end, then streams
// the whole data RAM as A5 <words LSB-first> 5A over a valid/ready byte link.
module ram_dump_streamer
  import riscv32s_pkg::*;
#(
  parameter int         RAMDEPTH = DUMP_RAMDEPTH,
  parameter int         AW       = (RAMDEPTH > 1) ? $clog2(RAMDEPTH) : 1,
  parameter logic [7:0] HDR_BYTE = DUMP_HDR_BYTE,
  parameter logic [7:0] TRL_BYTE = DUMP_TRL_BYTE
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic [31:0]         pc,
  input  logic [31:0]         proglen,
  output logic                core_halt,
  output logic                ram_ren,
  output logic [AW-1:0]       ram_addr,
  input  logic [31:0]         ram_rdata,
  ram_dump_streamer_if.master tx,
  output logic                busy,
  output logic                done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(RAMDEPTH - 1);

  dump_state_e   state;
  dump_state_e   state_nxt;
  logic [AW-1:0] index;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_nxt;
  logic [7:0]    tx_data_nxt;
  logic          handshake;
  logic          ser_load;
  logic          ser_advance;
  logic [7:0]    ser_next_byte;
  logic          ser_last;
  logic          unused_pc_lsb;

  // Instruction index is the word-aligned pc; the byte offset bits carry nothing.
  assign unused_pc_lsb = ^pc[1:0];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      core_halt <= 1'b0;
    end else if ({2'b00, pc[31:2]} >= proglen) begin
      core_halt <= 1'b1;
    end
  end

  assign handshake = tx_valid_q && tx.ready;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= DUMP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DUMP_IDLE: if (core_halt) state_nxt = DUMP_HDR;
      DUMP_HDR:  if (handshake) state_nxt = DUMP_RD;
      DUMP_RD:   state_nxt = DUMP_WAIT;
      DUMP_WAIT: state_nxt = DUMP_SEND;
      DUMP_SEND: begin
        if (handshake && ser_last) begin
          state_nxt = (index == LAST_IDX) ? DUMP_TRL : DUMP_RD;
        end
      end
      DUMP_TRL:  if (handshake) state_nxt = DUMP_DONE;
      DUMP_DONE: state_nxt = DUMP_DONE;
      default:   state_nxt = DUMP_IDLE;
    endcase
  end

  always_comb begin
    ram_ren     = (state == DUMP_RD);
    busy        = (state != DUMP_IDLE) && (state != DUMP_DONE);
    done        = (state == DUMP_DONE);
    ser_load    = (state == DUMP_WAIT);
    ser_advance = (state == DUMP_SEND) && handshake;
  end

  byte_serializer u_serializer (
    .clock     (clock),
    .nreset    (nreset),
    .load      (ser_load),
    .word      (ram_rdata),
    .advance   (ser_advance),
    .next_byte (ser_next_byte),
    .last      (ser_last)
  );

  // The stream registers are loaded from the next state, so a stalled byte
  // recomputes to the same value and valid never drops before its handshake.
  always_comb begin
    tx_valid_nxt = 1'b0;
    tx_data_nxt  = tx_data_q;
    case (state_nxt)
      DUMP_HDR: begin
        tx_valid_nxt = 1'b1;
        tx_data_nxt  = HDR_BYTE;
      end
      DUMP_SEND: begin
        tx_valid_nxt = 1'b1;
        tx_data_nxt  = ser_next_byte;
      end
      DUMP_TRL: begin
        tx_valid_nxt = 1'b1;
        tx_data_nxt  = TRL_BYTE;
      end
      default: begin
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = tx_data_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      index      <= '0;
    end else begin
      tx_valid_q <= tx_valid_nxt;
      tx_data_q  <= tx_data_nxt;
      if (ser_advance && ser_last && (index != LAST_IDX)) begin
        index <= index + AW'(1);
      end
    end
  end

  assign tx.valid = tx_valid_q;
  assign tx.data  = tx_data_q;
  assign ram_addr = index;

endmodule

// File: tb/tb_ram_dump_streamer.sv
// Directed bench: a full-depth streamer and a depth-3 streamer, each with a
// behavioural RAM, byte capture, and a hold-while-stalled monitor.
module tb_ram_dump_streamer;
  import riscv32s_pkg::*;

  localparam int DEPTH_A = DUMP_RAMDEPTH;
  localparam int DEPTH_B = 3;
  localparam int AW_A    = $clog2(DEPTH_A);
  localparam int AW_B    = 2;
  localparam int FRAME_A = 2 + 4 * DEPTH_A;
  localparam int FRAME_B = 2 + 4 * DEPTH_B;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              nreset_a, nreset_b;
  logic [31:0]       pc_a, pc_b, proglen_a, proglen_b;
  logic              core_halt_a, core_halt_b;
  logic              ram_ren_a, ram_ren_b;
  logic [AW_A-1:0]   ram_addr_a;
  logic [AW_B-1:0]   ram_addr_b;
  logic [31:0]       rdata_a, rdata_b;
  logic              busy_a, busy_b, done_a, done_b;
  logic [31:0]       mem_a [DEPTH_A];
  logic [31:0]       mem_b [DEPTH_B];

  ram_dump_streamer_if tx_a ();
  ram_dump_streamer_if tx_b ();

  ram_dump_streamer dut_a (
    .clock(clock), .nreset(nreset_a), .pc(pc_a), .proglen(proglen_a),
    .core_halt(core_halt_a), .ram_ren(ram_ren_a), .ram_addr(ram_addr_a),
    .ram_rdata(rdata_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  ram_dump_streamer #(.RAMDEPTH(DEPTH_B)) dut_b (
    .clock(clock), .nreset(nreset_b), .pc(pc_b), .proglen(proglen_b),
    .core_halt(core_halt_b), .ram_ren(ram_ren_b), .ram_addr(ram_addr_b),
    .ram_rdata(rdata_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  always @(posedge clock) begin
    if (ram_ren_a) rdata_a <= mem_a[ram_addr_a];
    if (ram_ren_b) rdata_b <= mem_b[ram_addr_b];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  int         unstable_a = 0, unstable_b = 0, max_addr_b = 0;
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] held_a, held_b;

  always @(negedge clock) begin
    if (hold_a && nreset_a && (!tx_a.valid || tx_a.data !== held_a)) unstable_a++;
    if (hold_b && nreset_b && (!tx_b.valid || tx_b.data !== held_b)) unstable_b++;
    hold_a = tx_a.valid && !tx_a.ready;
    held_a = tx_a.data;
    hold_b = tx_b.valid && !tx_b.ready;
    held_b = tx_b.data;
    if (tx_a.valid && tx_a.ready) cap_a.push_back(tx_a.data);
    if (tx_b.valid && tx_b.ready) cap_b.push_back(tx_b.data);
    if (ram_ren_b && int'(ram_addr_b) > max_addr_b) max_addr_b = int'(ram_addr_b);
  end

  logic [7:0] exp_b [FRAME_B] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h5A};
  logic [7:0] exp_first_a [5] = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11};

  task automatic reset_a(input logic [31:0] plen);
    nreset_a  = 1'b0;
    proglen_a = plen;
    pc_a      = '0;
    tx_a.ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    cap_a.delete();
    nreset_a = 1'b1;
  endtask

  task automatic reset_b();
    nreset_b  = 1'b0;
    proglen_b = '0;
    pc_b      = '0;
    tx_b.ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    cap_b.delete();
    max_addr_b = 0;
    nreset_b = 1'b1;
  endtask

  task automatic run_a(input int budget);
    for (int i = 0; i < budget && !done_a; i++) @(posedge clock);
    #1;
  endtask

  task automatic run_b(input int budget, input bit throttle);
    for (int i = 0; i < budget && !done_b; i++) begin
      @(posedge clock);
      #1;
      if (throttle) tx_b.ready = ($urandom_range(0, 2) == 0);
    end
    tx_b.ready = 1'b1;
  endtask

  task automatic check_frame_a(input string tag);
    int         mism;
    logic [31:0] w;
    logic [7:0]  e;
    mism = 0;
    for (int i = 0; i < cap_a.size(); i++) begin
      if (i == 0) e = 8'hA5;
      else if (i == FRAME_A - 1) e = 8'h5A;
      else begin
        w = mem_a[(i - 1) / 4];
        e = w[8 * ((i - 1) % 4) +: 8];
      end
      if (cap_a[i] !== e) mism++;
    end
    check({tag, "_size"}, cap_a.size(), FRAME_A);
    check({tag, "_content"}, mism, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH_A; i++) begin
      logic [15:0] k;
      k = i[15:0];
      mem_a[i] = {k[7:0] ^ 8'h5C, k[15:8], ~k[7:0], k[7:0]};
    end
    mem_a[0] = 32'h1122_3344;
    mem_b[0] = 32'hFFFF_FFFF;
    mem_b[1] = 32'h0000_0000;
    mem_b[2] = 32'h0000_0007;
    nreset_a = 1'b0; nreset_b = 1'b0;
    pc_a = '0; pc_b = '0; proglen_a = '0; proglen_b = '0;
    tx_a.ready = 1'b1; tx_b.ready = 1'b1;

    // Reset values, then proglen=0 halts one clock after release.
    repeat (3) @(posedge clock);
    #1;
    check("rst_core_halt", core_halt_a, 0);
    check("rst_tx_valid", tx_a.valid, 0);
    check("rst_tx_data", tx_a.data, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_ram_ren", ram_ren_a, 0);
    check("rst_ram_addr", ram_addr_a, 0);
    @(negedge clock);
    nreset_a = 1'b1;
    @(posedge clock);
    #1;
    check("halt_after_1clk", core_halt_a, 1);
    check("idle_no_valid", tx_a.valid, 0);
    @(posedge clock);
    #1;
    check("hdr_valid", tx_a.valid, 1);
    check("hdr_data", tx_a.data, 8'hA5);
    check("hdr_busy", busy_a, 1);
    run_a(8000);
    check("p0_done", done_a, 1);
    check("p0_busy_low", busy_a, 0);
    check("p0_valid_low", tx_a.valid, 0);
    check_frame_a("p0_frame");

    // proglen=5: halt only once pc reaches 20.
    reset_a(32'd5);
    for (int k = 0; k <= 5; k++) begin
      pc_a = 32'(4 * k);
      @(posedge clock);
      #1;
      if (k == 4) check("no_halt_pc16", core_halt_a, 0);
    end
    check("halt_pc20", core_halt_a, 1);
    run_a(8000);
    for (int i = 0; i < 5; i++) check($sformatf("p5_byte%0d", i), cap_a[i], exp_first_a[i]);
    check("p5_last_byte", cap_a[FRAME_A - 1], 8'h5A);
    check_frame_a("p5_frame");

    // Depth-3 instance, full rate then throttled.
    reset_b();
    run_b(200, 1'b0);
    check("d3_done", done_b, 1);
    check("d3_size", cap_b.size(), FRAME_B);
    for (int i = 0; i < FRAME_B; i++) check($sformatf("d3_byte%0d", i), cap_b[i], exp_b[i]);
    check("d3_max_addr", max_addr_b, 2);

    reset_b();
    run_b(800, 1'b1);
    begin
      int mism;
      mism = 0;
      for (int i = 0; i < FRAME_B; i++) if (cap_b[i] !== exp_b[i]) mism++;
      check("thr_done", done_b, 1);
      check("thr_size", cap_b.size(), FRAME_B);
      check("thr_content", mism, 0);
    end
    check("thr_hold_stable", unstable_b, 0);
    check("thr_max_addr", max_addr_b, 2);

    // Asynchronous reset in the middle of SEND.
    reset_a(32'd0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #2;
      if (cap_a.size() >= 7) break;
    end
    check("mid_valid", tx_a.valid, 1);
    check("mid_busy", busy_a, 1);
    nreset_a = 1'b0;
    #1;
    check("async_valid_drop", tx_a.valid, 0);
    check("async_halt_drop", core_halt_a, 0);
    check("async_busy_drop", busy_a, 0);
    @(negedge clock);
    #1;
    cap_a.delete();
    nreset_a = 1'b1;
    run_a(8000);
    check("restart_done", done_a, 1);
    check("restart_first", cap_a[0], 8'hA5);
    check_frame_a("restart_frame");

    // A fresh halt condition after done must not start another frame.
    proglen_a = 32'd10;
    pc_a = '0;
    repeat (20) @(posedge clock);
    pc_a = 32'd100;
    repeat (20) @(posedge clock);
    #1;
    check("post_done_sticky", done_a, 1);
    check("post_no_valid", tx_a.valid, 0);
    check("post_no_frame", cap_a.size(), FRAME_A);
    check("a_hold_stable", unstable_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
